// File: rtl/operand_sequencer_if.sv
// Nibble-stream and adder-operand bundle for operand_sequencer.
// slave = the sequencer, master = its environment (upstream, adder, downstream).
interface operand_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_nib;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic [15:0] sum;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_nib;
  logic        out_last;
  logic        ovf;

  modport slave (
    input  in_valid, in_nib, sum, out_ready,
    output in_ready, op_a, op_b, out_valid, out_nib, out_last, ovf
  );

  modport master (
    output in_valid, in_nib, sum, out_ready,
    input  in_ready, op_a, op_b, out_valid, out_nib, out_last, ovf
  );
endinterface

// File: rtl/operand_sequencer.sv
// Nibble-serial operand loader / result streamer around a 16-bit combinational adder.
// Optional carry-out reporting is enabled by defining OPSEQ_OVF_EN.
module operand_sequencer #(
  parameter int unsigned ADD_WAIT = 1
) (
  input  logic                 clk,
  input  logic                 nrst,
  operand_sequencer_if.slave   bus
);
  typedef enum logic [1:0] {LOAD_A, LOAD_B, ADD, SEND} state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  wcnt_q, wcnt_d;
  logic [15:0] op_a_q, op_a_d;
  logic [15:0] op_b_q, op_b_d;
  logic [15:0] res_q, res_d;
  logic        in_ready_q, in_ready_d;
`ifdef OPSEQ_OVF_EN
  logic        ovf_r_q, ovf_r_d;
`endif

  logic in_acc, out_acc;
  assign in_acc  = bus.in_valid & in_ready_q;
  assign out_acc = (state_q == SEND) & bus.out_ready;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wcnt_d  = wcnt_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    res_d   = res_q;
`ifdef OPSEQ_OVF_EN
    ovf_r_d = ovf_r_q;
`endif
    case (state_q)
      LOAD_A: if (in_acc) begin
        op_a_d[4*idx_q +: 4] = bus.in_nib;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = LOAD_B;
      end
      LOAD_B: if (in_acc) begin
        op_b_d[4*idx_q +: 4] = bus.in_nib;
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) begin
          state_d = ADD;
          wcnt_d  = 4'd0;
        end
      end
      ADD: begin
        wcnt_d = wcnt_q + 4'd1;
        if (wcnt_q == 4'(ADD_WAIT - 1)) begin
          res_d   = bus.sum;
`ifdef OPSEQ_OVF_EN
          // a wrapped unsigned sum is smaller than either addend
          ovf_r_d = (bus.sum < op_a_q);
`endif
          state_d = SEND;
          idx_d   = 2'd0;
        end
      end
      SEND: if (out_acc) begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = LOAD_A;
      end
      default: state_d = LOAD_A;
    endcase
    // registered so it stays low for the first cycle out of reset
    in_ready_d = (state_d == LOAD_A) || (state_d == LOAD_B);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= LOAD_A;
      idx_q      <= 2'd0;
      wcnt_q     <= 4'd0;
      op_a_q     <= 16'h0;
      op_b_q     <= 16'h0;
      res_q      <= 16'h0;
      in_ready_q <= 1'b0;
`ifdef OPSEQ_OVF_EN
      ovf_r_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wcnt_q     <= wcnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      in_ready_q <= in_ready_d;
`ifdef OPSEQ_OVF_EN
      ovf_r_q    <= ovf_r_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.op_a      = op_a_q;
  assign bus.op_b      = op_b_q;
  assign bus.out_valid = (state_q == SEND);
  assign bus.out_nib   = (state_q == SEND) ? res_q[4*idx_q +: 4] : 4'h0;
  assign bus.out_last  = (state_q == SEND) && (idx_q == 2'd3);
`ifdef OPSEQ_OVF_EN
  assign bus.ovf       = (state_q == SEND) & ovf_r_q;
`else
  assign bus.ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_operand_sequencer.sv
// Randomized self-checking bench for operand_sequencer; two instances (ADD_WAIT 1 and 4)
// share stimulus, sel picks which one is observed.
module tb_operand_sequencer;
  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic in_valid = 1'b0;
  logic [3:0] in_nib = 4'h0;
  logic out_ready = 1'b1;
  logic sel = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_sequencer_if ifc0();
  operand_sequencer_if ifc1();

  assign ifc0.in_valid = in_valid;  assign ifc1.in_valid = in_valid;
  assign ifc0.in_nib = in_nib;      assign ifc1.in_nib = in_nib;
  assign ifc0.out_ready = out_ready; assign ifc1.out_ready = out_ready;
  assign ifc0.sum = ifc0.op_a + ifc0.op_b;
  assign ifc1.sum = ifc1.op_a + ifc1.op_b;

  operand_sequencer #(.ADD_WAIT(1)) dut0 (.clk(clk), .nrst(nrst), .bus(ifc0));
  operand_sequencer #(.ADD_WAIT(4)) dut1 (.clk(clk), .nrst(nrst), .bus(ifc1));

  logic        o_in_ready, o_out_valid, o_out_last, o_ovf;
  logic [3:0]  o_out_nib;
  logic [15:0] o_op_a, o_op_b;
  assign o_in_ready  = sel ? ifc1.in_ready  : ifc0.in_ready;
  assign o_out_valid = sel ? ifc1.out_valid : ifc0.out_valid;
  assign o_out_last  = sel ? ifc1.out_last  : ifc0.out_last;
  assign o_ovf       = sel ? ifc1.ovf       : ifc0.ovf;
  assign o_out_nib   = sel ? ifc1.out_nib   : ifc0.out_nib;
  assign o_op_a      = sel ? ifc1.op_a      : ifc0.op_a;
  assign o_op_b      = sel ? ifc1.op_b      : ifc0.op_b;

  function automatic logic exp_ovf(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
`ifdef OPSEQ_OVF_EN
    return s[16];
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({o_in_ready, o_out_valid, o_out_last, o_ovf, o_out_nib, o_op_a, o_op_b} !== 40'h0) begin
      errors++;
      $display("FAIL %s reset_vals: rdy=%b vld=%b last=%b ovf=%b nib=%h a=%h b=%h, required all 0",
               tag, o_in_ready, o_out_valid, o_out_last, o_ovf, o_out_nib, o_op_a, o_op_b);
    end
  endtask

  // entered and left at a negedge; n nibbles of {b,a}, LSB first
  task automatic send_ops(input logic [15:0] a, input logic [15:0] b, input bit gaps, input int n);
    logic [31:0] v;
    int w;
    v = {b, a};
    for (int k = 0; k < n; k++) begin
      if (gaps) begin in_valid = 1'b0; @(negedge clk); end
      in_valid = 1'b1;
      in_nib = v[4*k +: 4];
      w = 0;
      while (!o_in_ready && w < 100) begin @(negedge clk); w++; end
      checks++;
      if (!o_in_ready) begin
        errors++; $display("FAIL in_ready_timeout: nibble %0d never accepted, required in_ready=1", k);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_result(input logic [15:0] a, input logic [15:0] b);
    int k, want;
    k = 0;
    want = sel ? 4 : 1;
    while (!o_out_valid && k < 50) begin
      checks++;
      if (o_op_a !== a || o_op_b !== b || o_in_ready !== 1'b0) begin
        errors++;
        $display("FAIL add_hold: a=%h b=%h rdy=%b, required a=%h b=%h rdy=0", o_op_a, o_op_b, o_in_ready, a, b);
      end
      @(negedge clk); k++;
    end
    checks++;
    if (k !== want) begin
      errors++; $display("FAIL latency: out_valid after %0d edges, required %0d", k, want);
    end
  endtask

  task automatic recv(input logic [15:0] a, input logic [15:0] b, input int stall_i, input int stall_n, input int n);
    logic [15:0] r;
    logic [3:0]  en;
    r = a + b;
    for (int i = 0; i < n; i++) begin
      en = r[4*i +: 4];
      if (i == stall_i) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          @(negedge clk);
          checks++;
          if (o_out_valid !== 1'b1 || o_out_nib !== en || o_out_last !== (i == 3)) begin
            errors++;
            $display("FAIL stall_hold: vld=%b nib=%h last=%b, required vld=1 nib=%h last=%b",
                     o_out_valid, o_out_nib, o_out_last, en, (i == 3));
          end
        end
      end
      out_ready = 1'b1;
      checks++;
      if (o_out_valid !== 1'b1 || o_out_nib !== en || o_out_last !== (i == 3)) begin
        errors++;
        $display("FAIL out_nib%0d: vld=%b nib=%h last=%b, required vld=1 nib=%h last=%b (a=%h b=%h)",
                 i, o_out_valid, o_out_nib, o_out_last, en, (i == 3), a, b);
      end
      checks++;
      if (o_op_a !== a || o_op_b !== b) begin
        errors++; $display("FAIL send_hold: a=%h b=%h, required a=%h b=%h", o_op_a, o_op_b, a, b);
      end
      if (i == 3) begin
        checks++;
        if (o_ovf !== exp_ovf(a, b)) begin
          errors++; $display("FAIL ovf: got %b, required %b (a=%h b=%h)", o_ovf, exp_ovf(a, b), a, b);
        end
      end
      @(negedge clk);
    end
    if (n == 4) begin
      checks++;
      if (o_in_ready !== 1'b1 || o_out_valid !== 1'b0) begin
        errors++; $display("FAIL return_load: rdy=%b vld=%b, required rdy=1 vld=0", o_in_ready, o_out_valid);
      end
    end
  endtask

  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input bit gaps, input int stall_i, input int stall_n);
    send_ops(a, b, gaps, 8);
    wait_result(a, b);
    recv(a, b, stall_i, stall_n, 4);
  endtask

  task automatic do_reset(input string tag);
    #2 nrst = 1'b0;
    #1 check_reset_vals(tag);
    @(negedge clk); nrst = 1'b1;
    #1;
    checks++;
    if (o_in_ready !== 1'b0) begin
      errors++; $display("FAIL %s rdy_before_edge: got %b, required 0", tag, o_in_ready);
    end
    @(negedge clk);
    checks++;
    if (o_in_ready !== 1'b1) begin
      errors++; $display("FAIL %s rdy_after_edge: got %b, required 1", tag, o_in_ready);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    do_reset("por");
  endtask

  task automatic test_basic;     run_op(16'h1234, 16'h0FFF, 1'b0, -1, 0); endtask
  task automatic test_wrap;      run_op(16'hFFFF, 16'h0001, 1'b0, -1, 0); endtask
  task automatic test_gaps_stall; run_op(16'h00FF, 16'h0001, 1'b1, 1, 5); endtask

  task automatic test_reset_mid;
    send_ops(16'h5A5A, 16'hC3C3, 1'b0, 6);
    do_reset("mid_load_b");
    run_op(16'h0001, 16'h0002, 1'b0, -1, 0);
    send_ops(16'h7777, 16'h9999, 1'b0, 8);
    wait_result(16'h7777, 16'h9999);
    recv(16'h7777, 16'h9999, -1, 0, 1);
    do_reset("mid_send");
    run_op(16'h0001, 16'h0002, 1'b0, -1, 0);
  endtask

  task automatic test_back_to_back;
    run_op(16'hABCD, 16'h1111, 1'b0, -1, 0);
    run_op(16'h0F0F, 16'hF0F1, 1'b0, -1, 0);
    run_op(16'h4321, 16'h8765, 1'b0, -1, 0);
  endtask

  task automatic test_random(input int n);
    for (int t = 0; t < n; t++) begin
      logic [15:0] a, b;
      int si;
      a = 16'($urandom);
      b = 16'($urandom);
      si = $urandom_range(0, 4);
      run_op(a, b, 1'($urandom_range(0, 1)), (si == 4) ? -1 : si, $urandom_range(1, 3));
    end
  endtask

  task automatic test_settle;
    sel = 1'b1;
    do_reset("settle");
    run_op(16'h8000, 16'h8000, 1'b0, -1, 0);
    test_random(5);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_gaps_stall();
    test_reset_mid();
    test_back_to_back();
    test_random(20);
    test_settle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not complete, required completion");
    $fatal(1);
  end
endmodule
